uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver in `tt_um_uart`. It captures each completed byte (`rx_data`) together with its error flag on the rising edge of the receiver's `rx_ready`. It then presents the bytes first-word-fall-through to the host side with a pop handshake, occupancy status and a sticky overflow flag. Its purpose is to keep back-to-back frames from being lost while the consumer is slow.

---
 rtl/uart_rx_fifo.sv | 84 ++++++++
 tb/tb_uart_rx_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: one capture per rx_ready rising edge, first-word-fall-through head.
// Write visible one edge after capture; never stalls the receiver -- when full, pushes drop and set a sticky overflow.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          rx_error,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic          half_full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rdy_q;

  logic push, pop, wr_en, drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign half_full = (count_q >= HALF_CNT);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign {rd_err, rd_data} = mem_q[rp_q];

  // rdy_q resets high so a level already asserted at reset release is not taken as a new byte.
  assign push  = rx_ready & ~rdy_q;
  assign pop   = rd_en & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wp_d = wp_q + AW'(1);
    if (pop)   rp_d = rp_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdy_q      <= rx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= {rx_error, rx_data};
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs driven and outputs sampled on the falling edge.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic       half_full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_error     (rx_error),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .empty        (empty),
    .full         (full),
    .half_full    (half_full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of rx_ready, then one low cycle so the next call is a new edge.
  task automatic push_byte(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_d);
    check(tag, {24'h0, rd_data}, {24'h0, exp_d});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, {31'h0, empty}, 32'd1);
    check({tag, "_count"}, {27'h0, count}, 32'd0);
    check({tag, "_ovf"},   {31'h0, overflow}, 32'd0);
    check({tag, "_full"},  {31'h0, full}, 32'd0);
    check({tag, "_half"},  {31'h0, half_full}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0;
    rd_en = 1'b0; clr_overflow = 1'b0;
    #2;
    check_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Level held 20 cycles yields exactly one entry.
    rx_data = 8'h5A; rx_error = 1'b0; rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check("single_count", {27'h0, count}, 32'd1);
    check("single_err", {31'h0, rd_err}, 32'd0);
    pop_check("single_data", 8'h5A);
    check("single_empty", {31'h0, empty}, 32'd1);

    // Pop request while empty is a no-op.
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_idle("empty_pop");

    // Ordering and pointer wrap.
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    check("fill_full", {31'h0, full}, 32'd1);
    check("fill_count", {27'h0, count}, 32'd16);
    check("fill_half", {31'h0, half_full}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("pre_pop%0d", i), 8'(i));
    check("pop4_count", {27'h0, count}, 32'd12);
    for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i), 1'b0);
    check("wrap_full", {31'h0, full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap_cnt%0d", i), {27'h0, count}, 32'(16 - i));
      check($sformatf("wrap_half%0d", i), {31'h0, half_full}, (16 - i) >= 8 ? 32'd1 : 32'd0);
      pop_check($sformatf("wrap_rd%0d", i), (i < 12) ? 8'(4 + i) : 8'hA0 + 8'(i - 12));
    end
    check("wrap_empty", {31'h0, empty}, 32'd1);
    check("wrap_half_end", {31'h0, half_full}, 32'd0);

    // Overflow: drop, drop with clear (set wins), clear alone.
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b0);
    check("ovf_pre", {31'h0, overflow}, 32'd0);
    push_byte(8'hEE, 1'b0);
    check("ovf_set", {31'h0, overflow}, 32'd1);
    check("ovf_count", {27'h0, count}, 32'd16);
    rx_data = 8'hEF; rx_ready = 1'b1; clr_overflow = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", {31'h0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_clear", {31'h0, overflow}, 32'd0);

    // Push and pop together while full: head 0x10 leaves, 0x77 enters at the tail.
    rx_data = 8'h77; rx_ready = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rd_en = 1'b0;
    check("fullpp_count", {27'h0, count}, 32'd16);
    check("fullpp_ovf", {31'h0, overflow}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      pop_check($sformatf("fullpp_rd%0d", i), (i < 15) ? 8'h11 + 8'(i) : 8'h77);
    check("fullpp_empty", {31'h0, empty}, 32'd1);

    // Push and pop together while empty: only the push takes effect.
    rx_data = 8'h33; rx_ready = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rd_en = 1'b0;
    check("emptypp_count", {27'h0, count}, 32'd1);
    check("emptypp_data", {24'h0, rd_data}, 32'h33);
    @(negedge clk);
    pop_check("emptypp_pop", 8'h33);

    // Error flag travels with its byte.
    push_byte(8'h00, 1'b1);
    push_byte(8'h55, 1'b0);
    check("err_first", {31'h0, rd_err}, 32'd1);
    pop_check("err_first_data", 8'h00);
    check("err_second", {31'h0, rd_err}, 32'd0);
    pop_check("err_second_data", 8'h55);

    // Asynchronous reset mid-traffic with overflow set, rx_ready held high across release.
    for (int i = 0; i < 17; i++) push_byte(8'hC0 + 8'(i), 1'b0);
    check("rst_pre_ovf", {31'h0, overflow}, 32'd1);
    rx_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level_ignored", {31'h0, empty}, 32'd1);
    rx_ready = 1'b0;
    @(negedge clk);
    push_byte(8'h9C, 1'b0);
    check("post_rst_count", {27'h0, count}, 32'd1);
    pop_check("post_rst_data", 8'h9C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
